word48_assembler: RTL and testbench

WORD48_ASSEMBLER -- requirements
Module: word48_assembler

---
 rtl/word48_assembler.sv | 160 ++++++++++++++++
 tb/tb_word48_assembler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/word48_assembler.sv
// word48_assembler: packs an SOF-framed byte stream into big-endian 48-bit words
// with a one-entry output register, framing-error accounting and backpressure.
// Optional feature: define WORD48_TIMEOUT_EN to abandon a partial word after
// TIMEOUT_CYCLES cycles without an accepted byte.
module word48_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [47:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  err_count,
    output logic        err_pulse
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 48;
    localparam int unsigned PART_W = WORD_W - BYTE_W;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ERR_W  = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(5);

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_t;

    // Reject out-of-range timeout settings at elaboration.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("word48_assembler: TIMEOUT_CYCLES must be within 2..65535");
    end

    logic [CNT_W-1:0]  r_cnt;
    logic [PART_W-1:0] r_part;
    logic [WORD_W-1:0] r_out_word;
    logic              r_out_valid;
    logic [ERR_W-1:0]  r_err_count;
    logic              r_err_pulse;

    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PART_W-1:0] w_part_nxt;
    logic [PART_W-1:0] w_part_shift;
    logic [WORD_W-1:0] w_word_nxt;
    logic              w_valid_nxt;
    logic [ERR_W-1:0]  w_err_count_nxt;
    logic              w_err;
    logic              w_accept;
    logic              w_expire;
    state_t            w_state;

    // The last slot only opens once the output register can take the word.
    assign in_ready     = !rst && ((r_cnt != LAST_CNT) || !r_out_valid || out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_state      = (r_cnt == '0) ? ST_IDLE : ST_FILL;
    assign w_part_shift = {r_part[PART_W-BYTE_W-1:0], in_data};

`ifdef WORD48_TIMEOUT_EN
    localparam int unsigned GAP_W = 16;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] w_gap_nxt;

    // An accept in the expiry cycle wins, so expiry requires no accept.
    assign w_expire = (r_cnt != '0) && !w_accept && (r_gap == GAP_LAST);

    // Gap timer next value: idle cycles while a word is partially filled.
    always_comb begin
        w_gap_nxt = r_gap + GAP_W'(1);
        if (w_accept || (r_cnt == '0) || w_expire) begin
            w_gap_nxt = '0;
        end
    end

    // Gap timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap <= '0;
        end else begin
            r_gap <= w_gap_nxt;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    // Next-state and output decode; cnt doubles as the IDLE/FILL state.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_part_nxt  = r_part;
        w_word_nxt  = r_out_word;
        w_valid_nxt = r_out_valid && !out_ready;
        w_err       = 1'b0;
        if (w_accept) begin
            case (w_state)
                ST_IDLE: begin
                    if (in_sof) begin
                        w_cnt_nxt  = CNT_W'(1);
                        w_part_nxt = w_part_shift;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                ST_FILL: begin
                    if (in_sof) begin
                        w_cnt_nxt  = CNT_W'(1);
                        w_part_nxt = w_part_shift;
                        w_err      = 1'b1;
                    end else if (r_cnt == LAST_CNT) begin
                        w_word_nxt  = {r_part, in_data};
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                        w_part_nxt = w_part_shift;
                    end
                end
                default: begin
                    w_cnt_nxt = '0;
                end
            endcase
        end else if (w_expire) begin
            w_cnt_nxt = '0;
            w_err     = 1'b1;
        end
        w_err_count_nxt = r_err_count;
        if (w_err && (r_err_count != '1)) begin
            w_err_count_nxt = r_err_count + ERR_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_part      <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_err_count <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_part      <= w_part_nxt;
            r_out_word  <= w_word_nxt;
            r_out_valid <= w_valid_nxt;
            r_err_count <= w_err_count_nxt;
            r_err_pulse <= w_err;
        end
    end

    assign out_word  = r_out_word;
    assign out_valid = r_out_valid;
    assign err_count = r_err_count;
    assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_word48_assembler.sv
// tb_word48_assembler: scoreboard bench for word48_assembler with a queue-based
// reference model of word framing, backpressure and error accounting.
module tb_word48_assembler;
    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_sof;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  err_count;
    logic        err_pulse;

    word48_assembler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_count (err_count),
        .err_pulse (err_pulse)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [7:0]  m_bytes[$];
    logic [47:0] sb[$];
    logic        m_ovalid = 1'b0;
    logic        m_pulse  = 1'b0;
    int          m_errs   = 0;
    int          m_gap    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_err();
        m_pulse = 1'b1;
        if (m_errs < 255) m_errs++;
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step(input logic v, input logic s, input logic [7:0] d,
                        input logic ordy, input logic r, output logic acc);
        logic        m_ready;
        logic [47:0] w;
        in_valid  = v;
        in_sof    = s;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        @(negedge clk);
        m_ready = !r && ((m_bytes.size() < 5) || !m_ovalid || ordy);
        check("in_ready", 48'(in_ready), 48'(m_ready));
        check("out_valid", 48'(out_valid), 48'(m_ovalid));
        check("err_count", 48'(err_count), 48'(m_errs));
        check("err_pulse", 48'(err_pulse), 48'(m_pulse));
        acc = v && m_ready;
        @(posedge clk);
        if (r) begin
            m_bytes.delete();
            sb.delete();
            m_ovalid = 1'b0;
            m_pulse  = 1'b0;
            m_errs   = 0;
            m_gap    = 0;
        end else begin
            m_pulse = 1'b0;
            if (m_ovalid && ordy) m_ovalid = 1'b0;
            if (acc) begin
                m_gap = 0;
                if (s) begin
                    if (m_bytes.size() != 0) m_err();
                    m_bytes.delete();
                    m_bytes.push_back(d);
                end else if (m_bytes.size() == 0) begin
                    m_err();
                end else begin
                    m_bytes.push_back(d);
                    if (m_bytes.size() == 6) begin
                        w = '0;
                        foreach (m_bytes[i]) w = (w << 8) | 48'(m_bytes[i]);
                        sb.push_back(w);
                        m_ovalid = 1'b1;
                        m_bytes.delete();
                    end
                end
            end else if (m_bytes.size() != 0) begin
`ifdef WORD48_TIMEOUT_EN
                m_gap++;
                if (m_gap == int'(TMO)) begin
                    m_bytes.delete();
                    m_gap = 0;
                    m_err();
                end
`endif
            end else begin
                m_gap = 0;
            end
        end
        #1;
    endtask

    task automatic send_byte(input logic s, input logic [7:0] d, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 16 && !acc; k++) step(1'b1, s, d, ordy, 1'b0, acc);
        n_tests++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted, expected accept within 16 cycles", d);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, ordy, 1'b0, acc);
    endtask

    task automatic send_word(input logic [7:0] b0, input logic ordy);
        for (int k = 0; k < 6; k++) send_byte(k == 0, b0 + 8'(k), ordy);
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold stability.
    logic        held = 1'b0;
    logic [47:0] held_word = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (held && out_valid) check("hold_stable", out_word, held_word);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected no word", out_word);
                end else begin
                    check("out_word", out_word, sb.pop_front());
                end
            end
            held      = out_valid && !out_ready && !rst;
            held_word = out_word;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        check("rst_word", out_word, 48'h0);

        // Back-to-back word with downstream ready.
        for (int k = 1; k <= 6; k++) send_byte(k == 1, 8'(k), 1'b1);
        idle(3, 1'b1);

        // Two words under backpressure, then release on the final byte.
        send_word(8'h21, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(k == 0, 8'h31 + 8'(k), 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h36, 1'b0, 1'b0, acc);
        send_byte(1'b0, 8'h36, 1'b1);
        idle(3, 1'b1);

        // Restarted word: partial AA,BB discarded.
        send_byte(1'b1, 8'hAA, 1'b1);
        send_byte(1'b0, 8'hBB, 1'b1);
        send_word(8'h11, 1'b1);
        idle(3, 1'b1);
        check("restart_errs", 48'(err_count), 48'd1);

        // Stray bytes saturate the error counter.
        for (int k = 0; k < 300; k++) send_byte(1'b0, 8'($urandom), 1'b1);
        check("err_sat", 48'(err_count), 48'd255);
        idle(2, 1'b1);

        // Reset in the middle of a word.
        for (int k = 0; k < 3; k++) send_byte(k == 0, 8'h41 + 8'(k), 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
        check("rst_mid_word", out_word, 48'h0);
        check("rst_mid_errs", 48'(err_count), 48'd0);
        send_word(8'h51, 1'b1);
        idle(3, 1'b1);

`ifdef WORD48_TIMEOUT_EN
        // Partial word expires after TMO idle cycles.
        send_byte(1'b1, 8'h01, 1'b1);
        send_byte(1'b0, 8'h02, 1'b1);
        idle(int'(TMO), 1'b1);
        check("timeout_errs", 48'(err_count), 48'd1);
        // A byte landing in the expiry cycle wins over the timeout.
        send_byte(1'b1, 8'h01, 1'b1);
        send_byte(1'b0, 8'h02, 1'b1);
        idle(int'(TMO) - 1, 1'b1);
        for (int k = 3; k <= 6; k++) send_byte(1'b0, 8'(k), 1'b1);
        idle(2, 1'b1);
        check("expiry_accept_errs", 48'(err_count), 48'd1);
`endif

        // Randomized traffic with random backpressure and rare resets.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, 8'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0, acc);
        end
        idle(8, 1'b1);
        check("drain", 48'(sb.size()), 48'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
